fetch: RTL
==========

FETCH -- requirements
Module: fetch

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 n_stall  in  1  global pipeline enable; 0 freezes the stage.
REQ-004 dec_nstall  in  1  decode load-use hazard flag; 0 means decode holds its current instruction.
REQ-005 flush  in  1  redirect request from branch/jump resolution.
REQ-006 redirect_pc  in  27  byte address of the new fetch target; valid when flush=1.
REQ-007 imem_req  out  1  instruction-memory read request.
REQ-008 imem_addr  out  25  word address of the request, equal to fetch_pc[26:2].
REQ-009 imem_valid  in  1  read data return; responses arrive in order, latency 1..N cycles.
REQ-010 imem_data  in  32  returned instruction word.
REQ-011 inst  out  32  instruction presented to decode; 32'h0 (NOP) when empty.
REQ-012 pc  out  27  byte address of inst; 0 when empty.
REQ-013 inst_valid  out  1  inst/pc hold a real fetched instruction.

Function
REQ-014 consume = n_stall && dec_nstall; decode has taken the output this cycle only when consume=1.
REQ-015 fetch_pc advances by 4 (mod 2^27) on every cycle with imem_req=1 and flush=0.
REQ-016 imem_req = !rst && !flush && (queue_count + outstanding < FQ_DEPTH) && (outstanding < MAX_OUTST).
REQ-017 outstanding: +1 on req, -1 on imem_valid, unchanged when both occur; range 0..MAX_OUTST.
REQ-018 Each accepted response is pushed to a FQ_DEPTH=4 FIFO as {pc, data}, with pc taken from a side FIFO of issued addresses.
REQ-019 The credit rule in REQ-016 means the queue never overflows; a push when full is an assertion failure.
REQ-020 Output register load: if !inst_valid or consume, pop the queue head into inst/pc with inst_valid=1. If the queue is empty, load inst=32'h0, pc=0, inst_valid=0.
REQ-021 If inst_valid=1 and consume=0, inst/pc/inst_valid hold.
REQ-022 Responses always pass through the queue, so there is no same-cycle bypass. Minimum latency is 2 edges from response to output.
REQ-023 Flush (highest priority) takes effect at the edge:
- fetch_pc <= redirect_pc.
- Queue and address FIFO cleared.
- inst <= 0, pc <= 0, inst_valid <= 0.
- kill_cnt <= outstanding minus any response arriving this cycle.
REQ-024 While kill_cnt>0, each imem_valid decrements kill_cnt and outstanding, and its data is discarded.
REQ-025 A response arriving in the same cycle as flush is discarded.
REQ-026 Redirect timing with memory latency 1: flush at edge E0; imem_req with redirect address during E0..E1; imem_valid during E1..E2; queue write at E2; inst valid after E3.
REQ-027 n_stall=0 does not block imem requests or responses; only output consumption is gated.
REQ-028 redirect_pc[1:0] is ignored and treated as 0.

Reset
REQ-029 On rst:
- fetch_pc=RESET_PC (0).
- queue, address FIFO, outstanding and kill_cnt all 0.
- inst=0, pc=0, inst_valid=0, imem_req=0.
REQ-030 rst takes priority over flush.
REQ-031 rst asserted while requests are in flight: responses during rst are dropped. Responses after rst with outstanding=0 are ignored and must not be pushed.

Structure
REQ-032 Shared package holds PC_W=27, INST_W=32, FQ_DEPTH=4, MAX_OUTST=2, NOP_INST=32'h0, RESET_PC=27'h0 and the {pc,inst} entry struct.
REQ-033 One sub-module, fetch_queue: parametrized sync FIFO with push, pop, clear, count, full and empty. It is instantiated for entries; the address FIFO may reuse it.
REQ-034 No combinational path from imem_data to inst.

Verification
REQ-035 Reset release with memory latency 1 and no stalls: imem_addr sequence 0,1,2,...; inst_valid first high 3 edges after the first request; pc sequence 0,4,8,... in order.
REQ-036 Hold dec_nstall=0 for 5 cycles: inst/pc frozen, queue fills to 4, imem_req drops, nothing lost. On release pc continues +4 with no gaps or duplicates.
REQ-037 Flush with redirect_pc=27'h100 while 2 requests are in flight at latency 3: both stale responses discarded. Next inst_valid shows pc=27'h100 then 27'h104.
REQ-038 Flush in the same cycle as imem_valid and consume: the response is dropped, output is 0/invalid next cycle, and kill_cnt equals remaining in-flight count.
REQ-039 Wrap-around: redirect_pc=27'h7FFFFFC gives pc 27'h7FFFFFC then 27'h0000000.
REQ-040 rst for 1 cycle mid-stream with 2 outstanding: outputs 0, late responses ignored, fetch restarts at pc 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and the fetch-queue entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_W      = 27;
  localparam int INST_W    = 32;
  localparam int ADDR_W    = PC_W - 2;
  localparam int FQ_DEPTH  = 4;
  localparam int MAX_OUTST = 2;
  localparam int QCNT_W    = $clog2(FQ_DEPTH + 1);
  localparam int OUTST_W   = $clog2(MAX_OUTST + 1);

  localparam logic [INST_W-1:0] NOP_INST = 32'h0;
  localparam logic [PC_W-1:0]   RESET_PC = 27'h0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with clear; used for fetched entries and for issued addresses.
module fetch_queue #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      assert (!(push && full));
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: credit-limited memory requests, in-order response queue,
// registered output to decode, and flush with kill of stale in-flight responses.
module fetch
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              n_stall,
  input  logic              dec_nstall,
  input  logic              flush,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc,
  output logic              inst_valid
);

  logic [PC_W-1:0]    r_fetch_pc;
  logic [OUTST_W-1:0] r_outst;
  logic [OUTST_W-1:0] r_kill;
  logic [INST_W-1:0]  r_inst;
  logic [PC_W-1:0]    r_pc;
  logic               r_inst_valid;

  logic               w_consume;
  logic               w_resp;
  logic               w_kill_resp;
  logic               w_accept;
  logic               w_load;
  logic               w_q_pop;
  logic [QCNT_W:0]    w_inflight;
  logic [QCNT_W-1:0]  w_q_count;
  logic               w_q_full;
  logic               w_q_empty;
  fq_entry_t          w_q_din;
  fq_entry_t          w_q_head;
  logic [PC_W-1:0]    w_af_head;
  logic [OUTST_W-1:0] w_af_count;
  logic               w_af_full;
  logic               w_af_empty;

  assign w_consume   = n_stall && dec_nstall;
  // A response only counts when something is in flight; leftovers from before a reset are ignored.
  assign w_resp      = imem_valid && (r_outst != '0);
  assign w_kill_resp = w_resp && (r_kill != '0);
  assign w_accept    = w_resp && (r_kill == '0) && !flush && !rst;
  assign w_inflight  = {1'b0, w_q_count} + (QCNT_W + 1)'(r_outst);

  assign imem_req  = !rst && !flush && (w_inflight < (QCNT_W + 1)'(FQ_DEPTH))
                     && (r_outst < OUTST_W'(MAX_OUTST));
  assign imem_addr = r_fetch_pc[PC_W-1:2];

  assign w_load  = !r_inst_valid || w_consume;
  assign w_q_pop = w_load && !w_q_empty && !flush && !rst;
  assign w_q_din = '{pc: w_af_head, inst: imem_data};

  fetch_queue #(.W(PC_W), .DEPTH(MAX_OUTST)) u_addr_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (imem_req),
    .din   (r_fetch_pc),
    .pop   (w_accept),
    .dout  (w_af_head),
    .count (w_af_count),
    .full  (w_af_full),
    .empty (w_af_empty)
  );

  fetch_queue #(.W($bits(fq_entry_t)), .DEPTH(FQ_DEPTH)) u_entry_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (w_accept),
    .din   (w_q_din),
    .pop   (w_q_pop),
    .dout  (w_q_head),
    .count (w_q_count),
    .full  (w_q_full),
    .empty (w_q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_outst      <= '0;
      r_kill       <= '0;
      r_inst       <= NOP_INST;
      r_pc         <= '0;
      r_inst_valid <= 1'b0;
    end else if (flush) begin
      r_fetch_pc   <= {redirect_pc[PC_W-1:2], 2'b00};
      // Everything still in flight after this edge belongs to the old path.
      r_outst      <= r_outst - OUTST_W'(w_resp);
      r_kill       <= r_outst - OUTST_W'(w_resp);
      r_inst       <= NOP_INST;
      r_pc         <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      if (imem_req)
        r_fetch_pc <= r_fetch_pc + PC_W'(4);
      case ({imem_req, w_resp})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
      if (w_kill_resp)
        r_kill <= r_kill - 1'b1;
      if (w_load) begin
        if (!w_q_empty) begin
          r_inst       <= w_q_head.inst;
          r_pc         <= w_q_head.pc;
          r_inst_valid <= 1'b1;
        end else begin
          r_inst       <= NOP_INST;
          r_pc         <= '0;
          r_inst_valid <= 1'b0;
        end
      end
    end
  end

  assign inst       = r_inst;
  assign pc         = r_pc;
  assign inst_valid = r_inst_valid;

endmodule
